// File: rtl/sdram_word_bridge.sv
// sdram_word_bridge
// Splits one 32-bit host word access into two 16-bit accesses on an SDRAM
// controller port. The low half goes first, then the high half. Write halves
// whose byte-enable pair is 00 are skipped.
//
// Optional build macro: SDRAM_BRIDGE_TIMEOUT_EN. When it is defined, each WAIT
// state gives up after TIMEOUT_CYCLES clocks without port1_ack, and sets the
// sticky host_err flag. When it is undefined, the WAIT states wait forever and
// host_err is tied to 0.
//
// Ports
//   clk, init_n        clock; asynchronous active-low reset
//   host_req/ready     start pulse (taken only in IDLE) / idle indicator
//   host_we/a/d/be     request fields, sampled with host_req
//   host_q             read data, valid from host_done until the next request
//   host_done          one-cycle completion pulse
//   host_err           sticky timeout flag
//   port1_req/ack      controller request pulse / acknowledge pulse
//   port1_we/a/d/ds    controller request fields, held stable per half
//   port1_q            controller read data, sampled with port1_ack
module sdram_word_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        host_req,
  output logic        host_ready,
  input  logic        host_we,
  input  logic [22:1] host_a,
  input  logic [31:0] host_d,
  input  logic [3:0]  host_be,
  output logic [31:0] host_q,
  output logic        host_done,
  output logic        host_err,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic        port1_we,
  output logic [23:1] port1_a,
  output logic [15:0] port1_d,
  output logic [1:0]  port1_ds,
  input  logic [15:0] port1_q
);

  // The counter is 8 bits wide.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [2:0] {
    StIdle, StLoReq, StLoWait, StHiReq, StHiWait, StDone
  } state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [22:1] a_q;
  logic [31:0] d_q;
  logic [3:0]  be_q;
  logic [31:0] q_q, q_d;
  logic        done_q;
  logic        req_q;
  logic        p_we_q, p_we_d;
  logic [23:1] p_a_q, p_a_d;
  logic [15:0] p_d_q, p_d_d;
  logic [1:0]  p_ds_q, p_ds_d;
  logic        accept, skip_lo, skip_hi, issue_lo, issue_hi;
  logic        timeout;

  assign accept  = (state_q == StIdle) && host_req;
  assign skip_lo = we_q && (be_q[1:0] == 2'b00);
  assign skip_hi = we_q && (be_q[3:2] == 2'b00);
  // The low-half fields are loaded straight from the host inputs on accept.
  // The latched copies are not valid until the following cycle.
  assign issue_lo = accept && !(host_we && (host_be[1:0] == 2'b00));
  assign issue_hi = (state_d == StHiReq) && !skip_hi;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (host_req) state_d = (host_we && (host_be == 4'b0000)) ? StDone : StLoReq;
      end
      StLoReq:  state_d = skip_lo ? StHiReq : StLoWait;
      StLoWait: begin
        if (port1_ack)    state_d = StHiReq;
        else if (timeout) state_d = StDone;
      end
      StHiReq:  state_d = skip_hi ? StDone : StHiWait;
      StHiWait: begin
        if (port1_ack || timeout) state_d = StDone;
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // The port fields are registered. They change only when a new half is
  // issued, so they stay stable through the wait and past the acknowledge.
  always_comb begin
    p_we_d = p_we_q;
    p_a_d  = p_a_q;
    p_d_d  = p_d_q;
    p_ds_d = p_ds_q;
    if (issue_lo) begin
      p_we_d = host_we;
      p_a_d  = {host_a, 1'b0};
      p_d_d  = host_d[15:0];
      p_ds_d = host_we ? host_be[1:0] : 2'b11;
    end else if (issue_hi) begin
      p_we_d = we_q;
      p_a_d  = {a_q, 1'b1};
      p_d_d  = d_q[31:16];
      p_ds_d = we_q ? be_q[3:2] : 2'b11;
    end
  end

  always_comb begin
    q_d = q_q;
    if (port1_ack && !we_q) begin
      if (state_q == StLoWait) q_d[15:0]  = port1_q;
      if (state_q == StHiWait) q_d[31:16] = port1_q;
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      a_q     <= '0;
      d_q     <= '0;
      be_q    <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      p_we_q  <= 1'b0;
      p_a_q   <= '0;
      p_d_q   <= '0;
      p_ds_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q <= host_we;
        a_q  <= host_a;
        d_q  <= host_d;
        be_q <= host_be;
      end
      q_q    <= q_d;
      done_q <= (state_q == StDone);
      req_q  <= issue_lo || issue_hi;
      p_we_q <= p_we_d;
      p_a_q  <= p_a_d;
      p_d_q  <= p_d_d;
      p_ds_q <= p_ds_d;
    end
  end

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt_q;
  logic       err_q;
  logic       in_wait;

  assign in_wait = (state_q == StLoWait) || (state_q == StHiWait);
  // The count is 0 in the first wait cycle, so TmoLast marks wait cycle TIMEOUT_CYCLES.
  assign timeout = in_wait && !port1_ack && (tmo_cnt_q == TmoLast);

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if ((state_q == StLoReq) || (state_q == StHiReq)) tmo_cnt_q <= '0;
      else if (in_wait)                                 tmo_cnt_q <= tmo_cnt_q + 8'd1;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign host_err = err_q;
`else
  assign timeout  = 1'b0;
  assign host_err = 1'b0;
`endif

  assign host_ready = (state_q == StIdle);
  assign host_done  = done_q;
  assign host_q     = q_q;
  assign port1_req  = req_q;
  assign port1_we   = p_we_q;
  assign port1_a    = p_a_q;
  assign port1_d    = p_d_q;
  assign port1_ds   = p_ds_q;

endmodule

// File: tb/tb_sdram_word_bridge.sv
// Directed bench for sdram_word_bridge. The bench drives inputs and samples
// outputs on the falling clock edge. The bench itself acts as the SDRAM
// controller: it acknowledges each port1_req a set number of cycles later.
module tb_sdram_word_bridge;

  logic        clk = 1'b0;
  logic        init_n;
  logic        host_req;
  logic        host_ready;
  logic        host_we;
  logic [22:1] host_a;
  logic [31:0] host_d;
  logic [3:0]  host_be;
  logic [31:0] host_q;
  logic        host_done;
  logic        host_err;
  logic        port1_req;
  logic        port1_ack;
  logic        port1_we;
  logic [23:1] port1_a;
  logic [15:0] port1_d;
  logic [1:0]  port1_ds;
  logic [15:0] port1_q;

  int n_checks = 0;
  int n_errors = 0;

  // Fields recorded from each port1_req seen in the last transaction.
  int          n_req;
  logic [23:1] ra  [4];
  logic [15:0] rd  [4];
  logic [1:0]  rds [4];
  logic        rwe [4];
  logic [31:0] q_at_done;
  int          lat;

  sdram_word_bridge #(.TIMEOUT_CYCLES(255)) dut (
    .clk       (clk),
    .init_n    (init_n),
    .host_req  (host_req),
    .host_ready(host_ready),
    .host_we   (host_we),
    .host_a    (host_a),
    .host_d    (host_d),
    .host_be   (host_be),
    .host_q    (host_q),
    .host_done (host_done),
    .host_err  (host_err),
    .port1_req (port1_req),
    .port1_ack (port1_ack),
    .port1_we  (port1_we),
    .port1_a   (port1_a),
    .port1_d   (port1_d),
    .port1_ds  (port1_ds),
    .port1_q   (port1_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one host request and then plays the controller until host_done.
  // n_ack < 0 means the bench never acknowledges. lat is the number of cycles
  // from the host_req cycle to host_done, or -1 if the cycle bound runs out.
  task automatic run_txn(input logic we, input logic [22:1] a, input logic [31:0] d,
                         input logic [3:0] be, input int n_ack,
                         input logic [15:0] q_lo, input logic [15:0] q_hi);
    int cnt;
    @(negedge clk);
    host_req = 1'b1;
    host_we  = we;
    host_a   = a;
    host_d   = d;
    host_be  = be;
    n_req    = 0;
    lat      = -1;
    cnt      = -1;
    for (int cyc = 1; cyc <= 600 && lat < 0; cyc++) begin
      @(negedge clk);
      host_req  = 1'b0;
      port1_ack = 1'b0;
      if (port1_req) begin
        if (n_req < 4) begin
          ra[n_req]  = port1_a;
          rd[n_req]  = port1_d;
          rds[n_req] = port1_ds;
          rwe[n_req] = port1_we;
        end
        n_req++;
        cnt = n_ack;
      end
      if (cnt == 0) begin
        port1_ack = 1'b1;
        port1_q   = (n_req == 1) ? q_lo : q_hi;
        cnt       = -1;
      end else if (cnt > 0) begin
        cnt--;
      end
      if (host_done) begin
        lat       = cyc;
        q_at_done = host_q;
      end
    end
    port1_ack = 1'b0;
  endtask

  initial begin
    init_n    = 1'b0;
    host_req  = 1'b0;
    host_we   = 1'b0;
    host_a    = '0;
    host_d    = '0;
    host_be   = '0;
    port1_ack = 1'b0;
    port1_q   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(host_ready), 32'd1);
    check("rst_done",  32'(host_done),  32'd0);
    check("rst_err",   32'(host_err),   32'd0);
    check("rst_q",     host_q,          32'd0);
    check("rst_req",   32'(port1_req),  32'd0);
    check("rst_we",    32'(port1_we),   32'd0);
    check("rst_a",     32'(port1_a),    32'd0);
    check("rst_d",     32'(port1_d),    32'd0);
    check("rst_ds",    32'(port1_ds),   32'd0);
    init_n = 1'b1;

    // Full write, ack 3 cycles after each req
    run_txn(1'b1, 22'h000008, 32'hCAFEDEAD, 4'b1111, 3, 16'h0, 16'h0);
    check("wr_nreq", 32'(n_req),  32'd2);
    check("wr_a0",   32'(ra[0]),  32'h10);
    check("wr_d0",   32'(rd[0]),  32'hDEAD);
    check("wr_ds0",  32'(rds[0]), 32'h3);
    check("wr_we0",  32'(rwe[0]), 32'd1);
    check("wr_a1",   32'(ra[1]),  32'h11);
    check("wr_d1",   32'(rd[1]),  32'hCAFE);
    check("wr_ds1",  32'(rds[1]), 32'h3);
    check("wr_lat",  32'(lat),    32'd10);
    check("wr_q",    host_q,      32'd0);

    // Full read, ack 3 cycles after each req
    run_txn(1'b0, 22'h000008, 32'h0, 4'b0000, 3, 16'hBEEF, 16'h1234);
    check("rd_nreq", 32'(n_req),  32'd2);
    check("rd_a0",   32'(ra[0]),  32'h10);
    check("rd_a1",   32'(ra[1]),  32'h11);
    check("rd_ds0",  32'(rds[0]), 32'h3);
    check("rd_we0",  32'(rwe[0]), 32'd0);
    check("rd_q",    q_at_done,   32'h1234BEEF);
    check("rd_lat",  32'(lat),    32'd10);

    // Upper-half-only write
    run_txn(1'b1, 22'h000005, 32'h89AB4567, 4'b1100, 3, 16'h0, 16'h0);
    check("hi_nreq", 32'(n_req),  32'd1);
    check("hi_a",    32'(ra[0]),  32'h0B);
    check("hi_d",    32'(rd[0]),  32'h89AB);
    check("hi_ds",   32'(rds[0]), 32'h3);
    check("hi_lat",  32'(lat),    32'd7);
    check("hi_q",    host_q,      32'h1234BEEF);

    // Lower-half-only write with a partial byte enable
    run_txn(1'b1, 22'h000003, 32'h11223344, 4'b0010, 3, 16'h0, 16'h0);
    check("lo_nreq", 32'(n_req),  32'd1);
    check("lo_a",    32'(ra[0]),  32'h06);
    check("lo_d",    32'(rd[0]),  32'h3344);
    check("lo_ds",   32'(rds[0]), 32'h2);
    check("lo_lat",  32'(lat),    32'd7);

    // Empty write
    run_txn(1'b1, 22'h000007, 32'hFFFFFFFF, 4'b0000, 3, 16'h0, 16'h0);
    check("be0_nreq", 32'(n_req), 32'd0);
    check("be0_lat",  32'(lat),   32'd2);

    // Fast read, ack 1 cycle after each req
    run_txn(1'b0, 22'h3FFFFF, 32'h0, 4'b0000, 1, 16'h5A5A, 16'hA5A5);
    check("rd1_a0",  32'(ra[0]), 32'h7FFFFE);
    check("rd1_a1",  32'(ra[1]), 32'h7FFFFF);
    check("rd1_q",   q_at_done,  32'hA5A55A5A);
    check("rd1_lat", 32'(lat),   32'd6);

    // An ack in IDLE is ignored
    @(negedge clk);
    port1_ack = 1'b1;
    port1_q   = 16'hDEAD;
    @(negedge clk);
    port1_ack = 1'b0;
    check("idle_ack_ready", 32'(host_ready), 32'd1);
    check("idle_ack_req",   32'(port1_req),  32'd0);
    @(negedge clk);
    check("idle_ack_done",  32'(host_done),  32'd0);
    check("idle_ack_q",     host_q,          32'hA5A55A5A);

    // Reset during LO_WAIT
    host_req = 1'b1;
    host_we  = 1'b0;
    host_a   = 22'h000020;
    host_be  = 4'hF;
    @(negedge clk);
    host_req = 1'b0;
    check("mid_req", 32'(port1_req), 32'd1);
    @(negedge clk);
    check("mid_busy", 32'(host_ready), 32'd0);
    init_n = 1'b0;
    #1;
    check("mid_rst_req",   32'(port1_req),  32'd0);
    check("mid_rst_ready", 32'(host_ready), 32'd1);
    check("mid_rst_q",     host_q,          32'd0);
    @(negedge clk);
    init_n = 1'b1;
    run_txn(1'b0, 22'h000020, 32'h0, 4'b0000, 2, 16'h0F0F, 16'hF0F0);
    check("post_rst_nreq", 32'(n_req),  32'd2);
    check("post_rst_a0",   32'(ra[0]),  32'h40);
    check("post_rst_q",    q_at_done,   32'hF0F00F0F);
    check("post_rst_lat",  32'(lat),    32'd8);

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    // Ack never comes: 255 wait cycles, then DONE
    run_txn(1'b0, 22'h000040, 32'h0, 4'b0000, -1, 16'h0, 16'h0);
    check("tmo_nreq", 32'(n_req),    32'd1);
    check("tmo_lat",  32'(lat),      32'd258);
    check("tmo_err",  32'(host_err), 32'd1);
    run_txn(1'b1, 22'h000041, 32'h01020304, 4'hF, 2, 16'h0, 16'h0);
    check("tmo_after_lat", 32'(lat),      32'd8);
    check("tmo_sticky",    32'(host_err), 32'd1);
`else
    check("no_tmo_err", 32'(host_err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_word_bridge.md
SDRAM_WORD_BRIDGE -- requirements
Module: sdram_word_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, port1_ack wait limit in clocks (used only with SDRAM_BRIDGE_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 init_n  in  1  reset; asynchronous and active-low.
REQ-004 host_req  in  1  one-cycle start pulse; accepted only while host_ready=1.
REQ-005 host_ready  out  1  high in IDLE only.
REQ-006 host_we  in  1  1=write, 0=read; sampled with host_req.
REQ-007 host_a  in  22  32-bit word address [22:1]; sampled with host_req.
REQ-008 host_d  in  32  write data; sampled with host_req.
REQ-009 host_be  in  4  byte enables, bit0=host_d[7:0]; sampled with host_req.
REQ-010 host_q  out  32  read data; valid from the host_done cycle until the next accepted host_req.
REQ-011 host_done  out  1  one-cycle completion pulse.
REQ-012 host_err  out  1  sticky timeout flag (constant 0 without SDRAM_BRIDGE_TIMEOUT_EN).
REQ-013 port1_req  out  1  one-cycle request pulse to the SDRAM controller.
REQ-014 port1_ack  in  1  one-cycle acknowledge from the SDRAM controller.
REQ-015 port1_we, port1_a[23:1], port1_d[15:0], port1_ds[1:0]  out  controller request fields.
REQ-016 port1_q  in  16  controller read data; sampled on the edge where port1_ack=1.

Function
REQ-017 FSM states: IDLE, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, DONE.
REQ-018 IDLE + host_req: latch we/a/d/be; next state LO_REQ.
  - Exception: a write with host_be=0000 goes directly to DONE.
REQ-019 LO half: port1_a={host_a,1'b0}, port1_d=host_d[15:0], port1_ds=be[1:0] on writes and 2'b11 on reads.
REQ-020 HI half: port1_a={host_a,1'b1}, port1_d=host_d[31:16], port1_ds=be[3:2] on writes and 2'b11 on reads.
REQ-021 Write whose LO/HI byte-enable pair is 00: that half is skipped with no port1_req (LO_REQ->HI_REQ, or HI_REQ->DONE).
REQ-022 Reads always issue both halves, LO first.
REQ-023 port1_req=1 for exactly the single cycle in LO_REQ or HI_REQ; the state then moves to the matching WAIT.
REQ-024 port1_we/a/d/ds are held stable from the REQ cycle until the cycle after port1_ack.
REQ-025 LO_WAIT + port1_ack: read data goes to host_q[15:0]; next state HI_REQ.
REQ-026 HI_WAIT + port1_ack: read data goes to host_q[31:16]; next state DONE.
REQ-027 DONE: host_done=1 for one cycle, then IDLE.
REQ-028 Latency: read with ack arriving N cycles after each req is 2*(N+1)+2 clocks from host_req to host_done.
REQ-029 port1_ack outside a WAIT state is ignored.
REQ-030 host_req outside IDLE is ignored, with no queuing.
REQ-031 host_q is unchanged on writes.

Reset
REQ-032 init_n=0 forces IDLE asynchronously, including mid-transaction.
REQ-033 Reset values: host_ready=1, host_done=0, host_err=0, host_q=0, port1_req=0, port1_we=0, port1_a=0, port1_d=0, port1_ds=0, timeout counter=0.
REQ-034 Leaving reset takes effect on the first clk edge after init_n rises.

Configuration
REQ-035 Macro SDRAM_BRIDGE_TIMEOUT_EN defined: an 8-bit counter clears on each REQ state and increments each cycle in a WAIT state.
  - When the counter reaches TIMEOUT_CYCLES without port1_ack: host_err is set, the FSM goes to DONE, and host_q holds the halves captured so far.
  - host_err clears only on reset.
REQ-036 Macro undefined: no counter; the WAIT states wait indefinitely; host_err tied to 0.

Verification
REQ-037 Write a=0x000008, d=0xCAFEDEAD, be=1111, ack 3 cycles after each req.
  - Expect two port1_req pulses: a=0x000010 d=0xDEAD ds=11, then a=0x000011 d=0xCAFE ds=11.
  - Expect one host_done.
REQ-038 Read a=0x000008, port1_q=0xBEEF on the LO ack and 0x1234 on the HI ack.
  - Expect host_q=0x1234BEEF at host_done.
  - Expect host_done 10 cycles after host_req with ack delay 3.
REQ-039 Write be=1100.
  - Expect a single port1_req with a=odd address, ds=11, d=host_d[31:16].
REQ-040 Write be=0000.
  - Expect no port1_req and host_done 2 cycles after host_req.
REQ-041 Pull init_n low during LO_WAIT, then release.
  - Expect port1_req=0, host_ready=1, and a fresh read to complete correctly.
REQ-042 With SDRAM_BRIDGE_TIMEOUT_EN and port1_ack never asserted.
  - Expect host_err=1 and host_done after TIMEOUT_CYCLES WAIT cycles.
  - Expect host_err to stay 1 through later transactions.
